serial_subtractor_4bit: RTL

//   Bit-serial unsigned subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.

---
 rtl/serial_subtractor_4bit.sv | 101 ++++++++++
 1 files changed

// File: rtl/serial_subtractor_4bit.sv
// rtl/serial_subtractor_4bit.sv - bit-serial unsigned subtractor, LSB first, start/busy/done handshake
module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    count;

    logic             a_i;
    logic             b_i;
    logic             d_i;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;

    // Full-subtractor cell; the new difference bit enters the result from the MSB side
    always_comb begin
        a_i              = a_sr[0];
        b_i              = b_sr[0];
        d_i              = a_i ^ b_i ^ br;
        br_nxt           = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        res_nxt          = res_sr >> 1;
        res_nxt[WIDTH-1] = d_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            br         <= 1'b0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= borrow_in;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    br     <= br_nxt;
                    if (count == LAST) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= res_nxt;
                        borrow_out <= br_nxt;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
